// File: rtl/conv_job_sequencer.sv
// Job-level controller for one convolution accelerator instance.
// Accepts a job, pulses acc_start, waits for acc_done (with timeout), then
// drains the output memory through a 2-entry skid FIFO onto a valid/ready
// result stream with a last marker.
module conv_job_sequencer #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    output logic              job_ready,
    output logic              acc_start,
    input  logic              acc_done,
    output logic              out_rd_en,
    output logic [ADDR_W-1:0] out_addr,
    input  logic [DATA_W-1:0] out_rd_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_last,
    output logic              busy,
    output logic [CNT_W-1:0]  run_cycles,
    output logic              err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_ERR,
        S_DRAIN
    } state_t;

    localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]  LAST_C  = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state;
    logic [CNT_W-1:0]    run_cnt;
    logic                err_q;
    logic [ADDR_W:0]     issue_cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic                rd_pend;
    logic                pend_last;
    logic                head_valid;
    logic                head_last;
    logic [DATA_W-1:0]   head_data;
    logic                tail_valid;
    logic                tail_last;
    logic [DATA_W-1:0]   tail_data;

    logic                pop;
    logic                issue;
    logic [1:0]          occ;

    // Read issue: a pop in the same cycle frees one slot, keeping
    // buffered + in-flight words at no more than two.
    always_comb begin
        pop   = head_valid && res_ready;
        occ   = {1'b0, head_valid} + {1'b0, tail_valid} + {1'b0, rd_pend};
        issue = (state == S_DRAIN) && (issue_cnt < DEPTH_C) &&
                ((occ < 2'd2) || (pop && (occ == 2'd2)));
    end

    // Output decode from registered state and FIFO head.
    always_comb begin
        job_ready   = (state == S_IDLE);
        busy        = (state != S_IDLE);
        acc_start   = (state == S_START);
        out_rd_en   = issue;
        out_addr    = issue ? issue_cnt[ADDR_W-1:0] : addr_q;
        res_valid   = head_valid;
        res_data    = head_data;
        res_last    = head_valid && head_last;
        run_cycles  = run_cnt;
        err_timeout = err_q;
    end

    // Job FSM, run counter, read pointer and skid FIFO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            run_cnt    <= '0;
            err_q      <= 1'b0;
            issue_cnt  <= '0;
            addr_q     <= '0;
            rd_pend    <= 1'b0;
            pend_last  <= 1'b0;
            head_valid <= 1'b0;
            head_last  <= 1'b0;
            head_data  <= '0;
            tail_valid <= 1'b0;
            tail_last  <= 1'b0;
            tail_data  <= '0;
        end else begin
            rd_pend   <= issue;
            pend_last <= issue && (issue_cnt == LAST_C);
            if (issue) begin
                addr_q    <= issue_cnt[ADDR_W-1:0];
                issue_cnt <= issue_cnt + (ADDR_W + 1)'(1);
            end

            // Data returning from memory goes to head if the head is free
            // (or being popped with nothing behind it), otherwise to tail.
            if (pop) begin
                if (tail_valid) begin
                    head_data  <= tail_data;
                    head_last  <= tail_last;
                    head_valid <= 1'b1;
                    if (rd_pend) begin
                        tail_data  <= out_rd_data;
                        tail_last  <= pend_last;
                        tail_valid <= 1'b1;
                    end else begin
                        tail_valid <= 1'b0;
                    end
                end else if (rd_pend) begin
                    head_data  <= out_rd_data;
                    head_last  <= pend_last;
                    head_valid <= 1'b1;
                end else begin
                    head_valid <= 1'b0;
                end
            end else if (rd_pend) begin
                if (!head_valid) begin
                    head_data  <= out_rd_data;
                    head_last  <= pend_last;
                    head_valid <= 1'b1;
                end else begin
                    tail_data  <= out_rd_data;
                    tail_last  <= pend_last;
                    tail_valid <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (job_valid) begin
                        state     <= S_START;
                        run_cnt   <= '0;
                        err_q     <= 1'b0;
                        issue_cnt <= '0;
                    end
                end
                S_START: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (run_cnt != CNT_MAX) begin
                        run_cnt <= run_cnt + CNT_W'(1);
                    end
                    if (acc_done) begin
                        state <= S_DRAIN;
                    end else if (run_cnt == TO_LAST) begin
                        state <= S_ERR;
                    end
                end
                S_ERR: begin
                    err_q <= 1'b1;
                    state <= S_IDLE;
                end
                S_DRAIN: begin
                    if (pop && head_last) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_job_sequencer.sv
// Self-checking bench for conv_job_sequencer: table of jobs, a reset-mid-drain
// sequence and randomized jobs, checked against a job-level reference model.
module tb_conv_job_sequencer;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 6;
    localparam int DEPTH   = 64;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              job_valid;
    logic              job_ready;
    logic              acc_start;
    logic              acc_done;
    logic              out_rd_en;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_rd_data;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_last;
    logic              busy;
    logic [CNT_W-1:0]  run_cycles;
    logic              err_timeout;

    conv_job_sequencer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .acc_start  (acc_start),
        .acc_done   (acc_done),
        .out_rd_en  (out_rd_en),
        .out_addr   (out_addr),
        .out_rd_data(out_rd_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_last   (res_last),
        .busy       (busy),
        .run_cycles (run_cycles),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int delay;      // acc_done this many cycles after acc_start, <0 = never
        int ready_pct;  // res_ready probability in percent
        bit hold;       // keep job_valid high through the whole job
        bit rand_mem;   // random memory contents instead of i*3
        int exp_run;
        bit exp_err;
        int exp_words;
        int exp_ret;    // acc_start-to-IDLE cycles for aborted jobs, <0 = unchecked
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] mem [DEPTH];
    int cyc = 0;
    int ready_pct = 100;
    int issued = 0;
    int rx_idx = 0;
    int starts = 0;
    int job_count = 0;
    bit expect_quiet = 1'b1;
    bit stall_prev = 1'b0;
    logic [DATA_W-1:0] held_data;
    logic held_last;
    bit first_seen;
    int first_valid_cyc, first_hs_cyc, last_hs_cyc;
    bit hs_seen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Synchronous-read memory with one cycle of latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (out_rd_en) out_rd_data <= mem[out_addr];
    end

    // Result consumer with random backpressure.
    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            res_ready = ($urandom_range(99) < ready_pct);
        end
    end

    // Stream monitor: order, data, last marker, stability, outstanding reads.
    always @(negedge clk) begin
        if (expect_quiet) chk("quiet_outside_drain", {62'd0, out_rd_en, res_valid}, 64'd0);
        if (acc_start) starts++;
        if (out_rd_en) begin
            chk("out_addr_order", out_addr, issued);
            issued++;
        end
        if (res_valid) begin
            if (!first_seen) begin
                first_seen = 1'b1;
                first_valid_cyc = cyc;
            end
            if (stall_prev) begin
                chk("stall_data_stable", res_data, held_data);
                chk("stall_last_stable", res_last, held_last);
            end
            if (res_ready) begin
                if (rx_idx < DEPTH) begin
                    chk("res_data", res_data, mem[rx_idx]);
                    chk("res_last", res_last, (rx_idx == DEPTH - 1));
                end else begin
                    chk("extra_word_idx", rx_idx, DEPTH - 1);
                end
                if (!hs_seen) begin
                    hs_seen = 1'b1;
                    first_hs_cyc = cyc;
                end
                last_hs_cyc = cyc;
                rx_idx++;
            end
            stall_prev = !res_ready;
            held_data  = res_data;
            held_last  = res_last;
        end else begin
            if (stall_prev) chk("valid_dropped_while_stalled", res_valid, 1'b1);
            stall_prev = 1'b0;
        end
        chk("outstanding_le2", ((issued - rx_idx) <= 2), 1'b1);
    end

    task automatic fill_mem(input bit rnd);
        for (int i = 0; i < DEPTH; i++) mem[i] = rnd ? $urandom : DATA_W'(i * 3);
    endtask

    // Reference job outcome from the timeout rule alone.
    function automatic vec_t model(input int delay, input int pct, input bit hold, input bit rnd);
        vec_t v;
        v.delay = delay; v.ready_pct = pct; v.hold = hold; v.rand_mem = rnd;
        if (delay >= 1 && delay <= TIMEOUT) begin
            v.exp_run = delay; v.exp_err = 1'b0; v.exp_words = DEPTH; v.exp_ret = -1;
        end else begin
            v.exp_run = TIMEOUT; v.exp_err = 1'b1; v.exp_words = 0; v.exp_ret = TIMEOUT + 2;
        end
        return v;
    endfunction

    // One job; called at a negedge in IDLE, returns at the negedge of the next IDLE cycle.
    task automatic run_job(input vec_t v);
        int start_cyc, done_cyc, n;
        fill_mem(v.rand_mem);
        ready_pct = v.ready_pct;
        issued = 0; rx_idx = 0; first_seen = 0; hs_seen = 0; done_cyc = 0;
        chk("job_ready_idle", job_ready, 1'b1);
        job_valid = 1'b1;
        job_count++;
        @(posedge clk);
        #1;
        if (!v.hold) job_valid = 1'b0;
        @(negedge clk);
        start_cyc = cyc;
        chk("acc_start_latency", acc_start, 1'b1);
        chk("busy_in_start", busy, 1'b1);
        chk("run_cycles_cleared", run_cycles, 0);
        chk("err_timeout_cleared", err_timeout, 1'b0);
        if (v.delay >= 0) begin
            for (int k = 0; k < v.delay; k++) @(posedge clk);
            #1;
            acc_done = 1'b1;
            done_cyc = cyc;
            if (v.exp_words > 0) expect_quiet = 1'b0;
            @(posedge clk);
            #1;
            acc_done = 1'b0;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!job_ready && n < 3000);
        expect_quiet = 1'b1;
        chk("job_return_in_budget", job_ready, 1'b1);
        chk("run_cycles", run_cycles, v.exp_run);
        chk("err_timeout", err_timeout, v.exp_err);
        chk("words_received", rx_idx, v.exp_words);
        chk("reads_issued", issued, v.exp_words);
        chk("acc_start_count", starts, job_count);
        chk("busy_after", busy, 1'b0);
        if (v.exp_ret >= 0) chk("abort_return_cycle", cyc - start_cyc, v.exp_ret);
        if (v.exp_words > 0) begin
            chk("first_valid_latency", first_valid_cyc - done_cyc, 3);
            if (v.ready_pct >= 100) chk("consecutive_words", last_hs_cyc - first_hs_cyc, DEPTH - 1);
        end
    endtask

    vec_t tbl [8];

    initial begin
        int n;
        vec_t v;
        tbl[0] = '{10, 100, 1'b0, 1'b0, 10, 1'b0, DEPTH, -1};          // basic
        tbl[1] = '{10, 50,  1'b0, 1'b0, 10, 1'b0, DEPTH, -1};          // backpressure
        tbl[2] = '{-1, 100, 1'b0, 1'b0, 16, 1'b1, 0,     18};          // timeout
        tbl[3] = '{16, 100, 1'b0, 1'b0, 16, 1'b0, DEPTH, -1};          // done wins on last RUN cycle
        tbl[4] = '{17, 100, 1'b0, 1'b0, 16, 1'b1, 0,     18};          // done one cycle too late
        tbl[5] = '{5,  100, 1'b1, 1'b1, 5,  1'b0, DEPTH, -1};          // job_valid held high
        tbl[6] = '{3,  30,  1'b0, 1'b1, 3,  1'b0, DEPTH, -1};          // accepted straight after held job
        tbl[7] = '{1,  70,  1'b0, 1'b1, 1,  1'b0, DEPTH, -1};

        rst = 1'b0; job_valid = 1'b0; acc_done = 1'b0; out_rd_data = '0;
        fill_mem(1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_job_ready", job_ready, 1'b1);
        chk("rst_acc_start", acc_start, 1'b0);
        chk("rst_out_rd_en", out_rd_en, 1'b0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_last", res_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_run_cycles", run_cycles, 0);
        chk("rst_err_timeout", err_timeout, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_job(tbl[i]);

        // Reset in the middle of a drain, then a full job from address 0.
        fill_mem(1'b0);
        ready_pct = 100;
        issued = 0; rx_idx = 0;
        job_valid = 1'b1;
        job_count++;
        @(posedge clk);
        #1;
        job_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_acc_start", acc_start, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        acc_done = 1'b1;
        expect_quiet = 1'b0;
        @(posedge clk);
        #1;
        acc_done = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rx_idx < 21 && n < 500);
        chk("mid_rst_reached_word20", (rx_idx >= 21), 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        expect_quiet = 1'b1;
        issued = 0; rx_idx = 0; stall_prev = 1'b0;
        @(negedge clk);
        chk("mid_rst_job_ready", job_ready, 1'b1);
        chk("mid_rst_acc_start0", acc_start, 1'b0);
        chk("mid_rst_out_rd_en", out_rd_en, 1'b0);
        chk("mid_rst_out_addr", out_addr, 0);
        chk("mid_rst_res_valid", res_valid, 1'b0);
        chk("mid_rst_res_data", res_data, 0);
        chk("mid_rst_res_last", res_last, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_run_cycles", run_cycles, 0);
        chk("mid_rst_err_timeout", err_timeout, 1'b0);
        repeat (3) @(negedge clk);
        run_job(model(7, 100, 1'b0, 1'b0));

        // Randomized jobs against the reference outcome model.
        for (int j = 0; j < 6; j++) begin
            v = model(int'($urandom_range(1, 20)), int'($urandom_range(20, 100)), 1'b0, 1'b1);
            run_job(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv_job_sequencer.md
Name: conv_job_sequencer

Overview:
- Job-level controller for one convolution accelerator instance, either the HIR or the HLS core.
- Accepts a job request, issues the single-cycle start pulse, waits for completion with a cycle counter and a timeout.
- Drains the 64-word output memory through its synchronous read port (1-cycle read latency) onto a valid/ready result stream with last marker.
- Sits between the testbench/host and the accelerator plus the output memref_rd port.

Parameters:
- DATA_W, 32, result word width
- ADDR_W, 6, output memory address width
- DEPTH, 64, number of output words drained per job (≤ 2^ADDR_W)
- CNT_W, 16, width of the run-cycle counter
- TIMEOUT, 4096, RUN cycles without acc_done before abort (< 2^CNT_W)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- job_valid  in  1  job request
- job_ready  out  1  high only in IDLE
- acc_start  out  1  start pulse to accelerator (drives its t / ap_start)
- acc_done  in  1  accelerator completion (single-cycle or level)
- out_rd_en  out  1  output memory read enable
- out_addr  out  ADDR_W  output memory read address
- out_rd_data  in  DATA_W  read data, valid the cycle after out_rd_en
- res_valid  out  1  result word valid
- res_ready  in  1  result consumer ready
- res_data  out  DATA_W  result word
- res_last  out  1  high with word DEPTH-1
- busy  out  1  state != IDLE
- run_cycles  out  CNT_W  RUN-cycle count of last job, held until next job accepted
- err_timeout  out  1  sticky abort flag, cleared on next job accept

Behaviour:
- Reset (rst==0 at a clk edge) forces IDLE, clears the skid buffer and in-flight tracking, and sets outputs to: job_ready=1, acc_start=0, out_rd_en=0, out_addr=0, res_valid=0, res_data=0, res_last=0, busy=0, run_cycles=0, err_timeout=0. Reset mid-job aborts the job and sends no further reads or results.
- States:
  - IDLE → START on job_valid&&job_ready. This edge clears run_cycles and err_timeout and resets the read and issue pointers to 0.
  - START: acc_start=1 for exactly this one cycle; acc_done is ignored. Always → RUN.
  - RUN: run_cycles increments each cycle, saturating at 2^CNT_W-1. If acc_done=1, increment then → DRAIN; acc_done wins over the timeout in the same cycle. Else if the counter equals TIMEOUT-1 in this cycle → ERR.
  - ERR: err_timeout←1; no drain; → IDLE next cycle.
  - DRAIN: reads addresses 0..DEPTH-1 in ascending order, one per cycle maximum. A read is issued only when (buffered words + reads in flight) < 2, using a 2-entry skid/output FIFO. Each read's data is captured the cycle after its out_rd_en. The FIFO head drives res_data/res_valid. res_last=1 exactly when the head is word DEPTH-1. After the res_valid&&res_ready handshake on the last word → IDLE next cycle.
- Latency: acc_start is high 1 cycle after job acceptance. With res_ready held high, the first result is valid 2 cycles after DRAIN entry and all DEPTH words complete in DEPTH+1 cycles of DRAIN.
- Stream rules: res_data/res_last stay stable while res_valid&&!res_ready. No res_valid outside DRAIN. out_rd_en=0 outside DRAIN and after address DEPTH-1 has been issued. out_addr holds its last value when not reading.
- job_valid outside IDLE is ignored and not queued. acc_done outside RUN is ignored.

Test Plan:
- Basic: DEPTH=64, mem[i]=i*3, job_valid 1 cycle, acc_done pulsed 10 cycles after acc_start, res_ready=1 → acc_start single pulse; run_cycles=10; 64 results 0,3,…,189 in order on consecutive cycles; res_last only on 189; job_ready=1 after.
- Backpressure: same job, res_ready toggled pseudo-randomly (50%) → identical data sequence, no drops or duplicates, data stable while stalled, never more than 2 reads outstanding+buffered.
- Timeout: TIMEOUT=16, acc_done never → ERR after 16 RUN cycles; err_timeout=1; no out_rd_en and no res_valid; next job accept clears err_timeout.
- Done/timeout collision: TIMEOUT=16, acc_done asserted on the 16th RUN cycle → DRAIN entered, err_timeout=0, run_cycles=16.
- Busy rejection: job_valid held high throughout a job → exactly one acc_start per job; the second job starts only after the return to IDLE.
- Reset mid-drain: rst=0 after result 20 → next cycle all outputs at reset values; a new job drains from address 0 and produces all 64 words.
